muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage. Consumes register operands and funct3 from decode/register read; produces a result for the writeback mux.
- Handshake is start/busy/done. Control stalls PC and pipeline while busy=1.
- Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

---
 rtl/muldiv_unit.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit for the execute stage. The unit uses
// a start/busy/done handshake, and the pipeline is held while busy is high.
//
// Multiplies use radix-2 shift-add on operand magnitudes to build a
// 2*DATA_WIDTH product. Divides use radix-2 restoring division on operand
// magnitudes. The sign of each result is applied in the FIX state.
//
// Division by zero and signed overflow (most-negative / -1) skip the
// iterative CALC phase.
//
// Optional feature (macro MULDIV_FAST_MUL_EN):
//   defined   - all four multiplies use one combinational 2*DATA_WIDTH
//               product and take the short path (done two cycles after start).
//   undefined - multiplies iterate like divides.
//
// Parameters:
//   DATA_WIDTH  operand/result width (even, >= 8)
//   CNT_WIDTH   iteration counter width (must hold DATA_WIDTH)
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-low reset
//   start   in   request, sampled only when not busy
//   funct3  in   RV32M operation select
//   op_a    in   rs1 value
//   op_b    in   rs2 value
//   busy    out  operation in progress
//   done    out  one-cycle pulse, result valid
//   result  out  result register, held until the next accepted op completes
// ---------------------------------------------------------------------------
module muldiv_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int W = DATA_WIDTH;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

   localparam logic [W-1:0]   ZERO_W   = {W{1'b0}};
   localparam logic [W-1:0]   ALL_ONES = {W{1'b1}};
   localparam logic [W-1:0]   MIN_NEG  = {1'b1, {(W-1){1'b0}}};
   localparam logic [2*W-1:0] ZERO_2W  = {(2*W){1'b0}};

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_t;

   // op_a is treated as signed for MUL, MULH, MULHSU, DIV and REM.
   function automatic logic op_a_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
         default:                                    s = 1'b0;
      endcase
      return s;
   endfunction

   // op_b is treated as signed for MUL, MULH, DIV and REM.
   function automatic logic op_b_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         F3_MUL, F3_MULH, F3_DIV, F3_REM: s = 1'b1;
         default:                         s = 1'b0;
      endcase
      return s;
   endfunction

   // Registered state
   state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [2:0]       f3_q, f3_d;
   logic [2*W-1:0]   prod_q, prod_d;     // mul: {acc, multiplier}; div: {rem, quotient}
   logic [W-1:0]     opnd_q, opnd_d;     // mul: |multiplicand|; div: |divisor|
   logic             neg_q, neg_d;       // negate product / quotient in FIX
   logic             neg_rem_q, neg_rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [W-1:0]     result_q, result_d;

   // Combinational helpers
   logic             a_neg_s, b_neg_s;
   logic [W-1:0]     a_mag_s, b_mag_s;
   logic             div_zero_s, div_ovf_s;
   logic             fast_mul_s;
   logic [2*W-1:0]   fast_prod_s;
   logic [W:0]       mul_sum_s;
   logic [W:0]       rem_shift_s;
   logic [W:0]       rem_diff_s;
   logic [2*W-1:0]   step_prod_s;
   logic [2*W-1:0]   prod_fix_s;
   logic [W-1:0]     quo_fix_s, rem_fix_s;
   logic [W-1:0]     fix_res_s;

   // Operand conditioning for a new request: signs, magnitudes, short-path detect
   always_comb begin
      a_neg_s    = op_a_signed(funct3) & op_a[W-1];
      b_neg_s    = op_b_signed(funct3) & op_b[W-1];
      a_mag_s    = a_neg_s ? -op_a : op_a;
      b_mag_s    = b_neg_s ? -op_b : op_b;
      div_zero_s = funct3[2] & (op_b == ZERO_W);
      // Only the signed divide ops (funct3[0]==0) can overflow
      div_ovf_s  = funct3[2] & ~funct3[0] & (op_a == MIN_NEG) & (op_b == ALL_ONES);
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*W-1:0] a_ext_s, b_ext_s;

   // Single-cycle product; sign-extending to 2*W makes the low 2*W bits exact
   always_comb begin
      a_ext_s     = {{W{a_neg_s}}, op_a};
      b_ext_s     = {{W{b_neg_s}}, op_b};
      fast_prod_s = a_ext_s * b_ext_s;
   end

   assign fast_mul_s = ~funct3[2];
`else
   assign fast_prod_s = ZERO_2W;
   assign fast_mul_s  = 1'b0;
`endif

   // One radix-2 iteration: shift-add multiply or restoring divide
   always_comb begin
      mul_sum_s   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
      rem_shift_s = {prod_q[2*W-1:W], prod_q[W-1]};
      // A set MSB means the partial remainder is smaller than the divisor (restore)
      rem_diff_s  = rem_shift_s - {1'b0, opnd_q};
      if (f3_q[2]) begin
         if (rem_diff_s[W]) begin
            step_prod_s = {rem_shift_s[W-1:0], prod_q[W-2:0], 1'b0};
         end else begin
            step_prod_s = {rem_diff_s[W-1:0], prod_q[W-2:0], 1'b1};
         end
      end else begin
         step_prod_s = {mul_sum_s, prod_q[W-1:1]};
      end
   end

   // Sign correction and result selection used in FIX
   always_comb begin
      prod_fix_s = neg_q ? -prod_q : prod_q;
      quo_fix_s  = neg_q ? -prod_q[W-1:0] : prod_q[W-1:0];
      rem_fix_s  = neg_rem_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W];
      case (f3_q)
         F3_MUL:                       fix_res_s = prod_fix_s[W-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_res_s = prod_fix_s[2*W-1:W];
         F3_DIV, F3_DIVU:              fix_res_s = quo_fix_s;
         F3_REM, F3_REMU:              fix_res_s = rem_fix_s;
         default:                      fix_res_s = ZERO_W;
      endcase
   end

   // Next-state, handshake and datapath update
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      f3_d      = f3_q;
      prod_d    = prod_q;
      opnd_d    = opnd_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               f3_d  = funct3;
               cnt_d = CNT_ZERO;
               if (funct3[2]) begin
                  if (div_zero_s) begin
                     // Short path: quotient = all ones, remainder = op_a
                     prod_d    = {op_a, ALL_ONES};
                     opnd_d    = ZERO_W;
                     neg_d     = 1'b0;
                     neg_rem_d = 1'b0;
                     state_d   = S_FIX;
                  end else if (div_ovf_s) begin
                     // Short path: quotient = op_a, remainder = 0
                     prod_d    = {ZERO_W, op_a};
                     opnd_d    = ZERO_W;
                     neg_d     = 1'b0;
                     neg_rem_d = 1'b0;
                     state_d   = S_FIX;
                  end else begin
                     prod_d    = {ZERO_W, a_mag_s};
                     opnd_d    = b_mag_s;
                     neg_d     = a_neg_s ^ b_neg_s;
                     neg_rem_d = a_neg_s;
                     state_d   = S_CALC;
                  end
               end else if (fast_mul_s) begin
                  prod_d    = fast_prod_s;
                  opnd_d    = ZERO_W;
                  neg_d     = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = S_FIX;
               end else begin
                  prod_d    = {ZERO_W, b_mag_s};
                  opnd_d    = a_mag_s;
                  neg_d     = a_neg_s ^ b_neg_s;
                  neg_rem_d = 1'b0;
                  state_d   = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            prod_d = step_prod_s;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = CNT_ZERO;
               state_d = S_FIX;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = S_CALC;
            end
         end
         S_FIX: begin
            result_d = fix_res_s;
            state_d  = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_CALC) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   // All state and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= CNT_ZERO;
         f3_q      <= 3'b000;
         prod_q    <= ZERO_2W;
         opnd_q    <= ZERO_W;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= ZERO_W;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         f3_q      <= f3_d;
         prod_q    <= prod_d;
         opnd_q    <= opnd_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed self-checking bench for muldiv_unit. Expected values are
// hand-computed. "Cycle n" means the period after the n-th rising edge that
// follows the cycle in which start was driven. Inputs are driven and outputs
// are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_CYC = 2;
`else
   localparam int MUL_CYC = 34;
`endif

   logic         clk;
   logic         rst;
   logic         start;
   logic [2:0]   funct3;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;

   int total;
   int bad;

   muldiv_unit #(
      .DATA_WIDTH (W),
      .CNT_WIDTH  (6)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a request in the current cycle; returns in cycle 1
   task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      funct3 = f3;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      step();
      start  = 1'b0;
   endtask

   // Wait for done and check its cycle, result, busy cycles and exclusivity.
   // A stray start (MUL 3*3) is driven in cycle pulse_at when pulse_at > 0.
   task automatic wait_done(input string tag, input int exp_cyc,
                            input logic [31:0] exp_res, input int pulse_at);
      int c;
      int busy_cnt;
      int both;
      bit seen;
      busy_cnt = 0;
      both     = 0;
      seen     = 1'b0;
      for (c = 1; c <= 80; c++) begin
         if (busy === 1'b1 && done === 1'b1) both++;
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (busy === 1'b1) busy_cnt++;
         if (c == pulse_at) begin
            funct3 = 3'b000;
            op_a   = 32'd3;
            op_b   = 32'd3;
            start  = 1'b1;
         end else begin
            start  = 1'b0;
         end
         step();
      end
      start = 1'b0;
      if (!seen) c = 81;
      check({tag, " done_cycle"}, c, exp_cyc);
      check({tag, " result"}, result, exp_res);
      check({tag, " busy_cycles"}, busy_cnt, exp_cyc - 1);
      check({tag, " busy_and_done"}, both, 0);
   endtask

   initial begin
      int dcnt;
      int bcnt;
      total  = 0;
      bad    = 0;
      rst    = 1'b0;
      start  = 1'b0;
      funct3 = 3'b000;
      op_a   = 32'h0;
      op_b   = 32'h0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset result", result, 32'h0);
      rst = 1'b1;
      step();

      // MUL 7 * -3 with a one-cycle done pulse and the result held afterwards
      launch(3'b000, 32'd7, 32'hFFFF_FFFD);
      wait_done("mul", MUL_CYC, 32'hFFFF_FFEB, 0);
      step();
      check("mul done_pulse", {31'd0, done}, 32'd0);
      check("mul idle_busy", {31'd0, busy}, 32'd0);
      check("mul result_held", result, 32'hFFFF_FFEB);

      // High-half multiplies
      launch(3'b001, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("mulh", MUL_CYC, 32'h0000_0000, 0);
      launch(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("mulhu", MUL_CYC, 32'h7FFF_FFFF, 0);
      launch(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("mulhsu", MUL_CYC, 32'h8000_0000, 0);
      launch(3'b000, 32'h0001_2345, 32'hFFFF_0000);
      wait_done("mul_big", MUL_CYC, 32'hDCBB_0000, 0);

      // Iterative divides
      launch(3'b100, 32'hFFFF_FFF9, 32'd2);
      wait_done("div", 34, 32'hFFFF_FFFD, 0);
      launch(3'b110, 32'hFFFF_FFF9, 32'd2);
      wait_done("rem", 34, 32'hFFFF_FFFF, 0);
      launch(3'b101, 32'hFFFF_FFF9, 32'd2);
      wait_done("divu", 34, 32'h7FFF_FFFC, 0);
      launch(3'b111, 32'd100, 32'd7);
      wait_done("remu", 34, 32'd2, 0);

      // Short-path boundaries
      launch(3'b100, 32'd5, 32'd0);
      wait_done("div_by_zero", 2, 32'hFFFF_FFFF, 0);
      launch(3'b111, 32'd5, 32'd0);
      wait_done("remu_by_zero", 2, 32'd5, 0);
      launch(3'b110, 32'hFFFF_FFF9, 32'd0);
      wait_done("rem_by_zero", 2, 32'hFFFF_FFF9, 0);
      launch(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", 2, 32'h8000_0000, 0);
      launch(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("rem_ovf", 2, 32'h0000_0000, 0);

      // A start pulsed while busy is ignored
      launch(3'b100, 32'd100, 32'd7);
      wait_done("div_ignore", 34, 32'd14, 10);

      // A start in the done cycle is accepted at once
      launch(3'b101, 32'd9, 32'd3);
      wait_done("divu_first", 34, 32'd3, 0);
      launch(3'b101, 32'd20, 32'd4);
      check("b2b busy", {31'd0, busy}, 32'd1);
      check("b2b done", {31'd0, done}, 32'd0);
      check("b2b result_held", result, 32'd3);
      wait_done("divu_second", 34, 32'd5, 0);

      // Reset in cycle 15 of a divide aborts it
      launch(3'b100, 32'd100, 32'd7);
      repeat (14) step();
      rst = 1'b0;
      step();
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort result", result, 32'h0);
      rst  = 1'b1;
      dcnt = 0;
      bcnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (done === 1'b1) dcnt++;
         if (busy === 1'b1) bcnt++;
      end
      check("abort no_done", dcnt, 0);
      check("abort no_busy", bcnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
